// File: rtl/clk_align_fsm_pkg.sv
// rtl/clk_align_fsm_pkg.sv - shared state encoding and bitslip counter width for ADC frame alignment
package clk_align_fsm_pkg;

   localparam int BITSLIP_COUNT_W = 4;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETTLE  = 3'd1;
   localparam logic [2:0] ST_CHECK   = 3'd2;
   localparam logic [2:0] ST_SLIP    = 3'd3;
   localparam logic [2:0] ST_ALIGNED = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      SETTLE  = ST_SETTLE,
      CHECK   = ST_CHECK,
      SLIP    = ST_SLIP,
      ALIGNED = ST_ALIGNED
   } align_state_t;

   // The ISERDES only has deser_width distinct slip positions, so the count wraps there.
   function automatic logic [BITSLIP_COUNT_W-1:0] next_slip_count(
      input logic [BITSLIP_COUNT_W-1:0] count,
      input int                         deser_width
   );
      if (count == BITSLIP_COUNT_W'(deser_width - 1))
         return '0;
      return count + BITSLIP_COUNT_W'(1);
   endfunction

endpackage

// File: rtl/clk_align_fsm_counter.sv
// rtl/clk_align_fsm_counter.sv - saturating frame match/miss counter with synchronous clear
module frame_match_counter #(
   parameter  int LIMIT = 64,
   localparam int W     = $clog2(LIMIT + 1)
) (
   input  logic         adc_clock,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge adc_clock or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && count != W'(LIMIT))
         count <= count + W'(1);
   end

endmodule

// File: rtl/clk_align_fsm.sv
// rtl/clk_align_fsm.sv - bitslips the ADC ISERDES until the frame lane shows FRAME_PATTERN
module clk_align_fsm
   import clk_align_fsm_pkg::*;
#(
   parameter int         DESER_WIDTH   = 8,
   parameter logic [7:0] FRAME_PATTERN = 8'hF0,
   parameter int         SETTLE_CYCLES = 16,
   parameter int         CHECK_CYCLES  = 64,
   parameter int         MISS_LIMIT    = 4
) (
   input  logic                       adc_clock,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       mmcm_locked,
   input  logic [DESER_WIDTH-1:0]     frame_data,
   output logic                       serdes_rst,
   output logic                       bitslip,
   output logic [BITSLIP_COUNT_W-1:0] bitslip_count,
   output logic                       frame_valid,
   output logic                       align_wrap
);

   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int MATCH_W  = $clog2(CHECK_CYCLES + 1);
   localparam int MISS_W   = $clog2(MISS_LIMIT + 1);

   align_state_t        state;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [MATCH_W-1:0]  match_cnt;
   logic [MISS_W-1:0]   miss_cnt;
   logic                word_match;
   logic                run_ok;

   assign word_match = (frame_data == FRAME_PATTERN[DESER_WIDTH-1:0]);
   assign run_ok     = enable && mmcm_locked;

   // Leaving CHECK or ALIGNED always clears the corresponding run so re-entry starts from zero.
   frame_match_counter #(.LIMIT(CHECK_CYCLES)) u_match_cnt (
      .adc_clock (adc_clock),
      .rst       (rst),
      .clear     (state != CHECK),
      .inc       (state == CHECK && word_match),
      .count     (match_cnt)
   );

   frame_match_counter #(.LIMIT(MISS_LIMIT)) u_miss_cnt (
      .adc_clock (adc_clock),
      .rst       (rst),
      .clear     (state != ALIGNED || word_match),
      .inc       (state == ALIGNED && !word_match),
      .count     (miss_cnt)
   );

   always_ff @(posedge adc_clock or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         serdes_rst    <= 1'b1;
         bitslip       <= 1'b0;
         bitslip_count <= '0;
         frame_valid   <= 1'b0;
         align_wrap    <= 1'b0;
         settle_cnt    <= '0;
      end else if (!run_ok || state == IDLE) begin
         // Losing enable or lock outranks everything, including a slip about to be issued.
         state         <= run_ok ? SETTLE : IDLE;
         serdes_rst    <= !run_ok;
         bitslip       <= 1'b0;
         bitslip_count <= '0;
         frame_valid   <= 1'b0;
         align_wrap    <= 1'b0;
         settle_cnt    <= '0;
      end else begin
         bitslip <= 1'b0;
         case (state)
            SETTLE: begin
               if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                  state      <= CHECK;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + SETTLE_W'(1);
               end
            end
            CHECK: begin
               if (match_cnt == MATCH_W'(CHECK_CYCLES)) begin
                  state       <= ALIGNED;
                  frame_valid <= 1'b1;
               end else if (!word_match) begin
                  state         <= SLIP;
                  bitslip       <= 1'b1;
                  bitslip_count <= next_slip_count(bitslip_count, DESER_WIDTH);
                  if (bitslip_count == BITSLIP_COUNT_W'(DESER_WIDTH - 1))
                     align_wrap <= 1'b1;
               end
            end
            SLIP: begin
               state      <= SETTLE;
               settle_cnt <= '0;
            end
            ALIGNED: begin
               if (!word_match && miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
                  state       <= CHECK;
                  frame_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_align_fsm.sv
// tb/tb_clk_align_fsm.sv - directed self-checking bench for clk_align_fsm
module tb_clk_align_fsm;
   import clk_align_fsm_pkg::*;

   logic       adc_clock = 1'b0;
   logic       rst;
   logic       enable;
   logic       mmcm_locked;
   logic [7:0] frame_data;
   logic       serdes_rst;
   logic       bitslip;
   logic [3:0] bitslip_count;
   logic       frame_valid;
   logic       align_wrap;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   logic [7:0] lane_words [4];

   clk_align_fsm dut (
      .adc_clock     (adc_clock),
      .rst           (rst),
      .enable        (enable),
      .mmcm_locked   (mmcm_locked),
      .frame_data    (frame_data),
      .serdes_rst    (serdes_rst),
      .bitslip       (bitslip),
      .bitslip_count (bitslip_count),
      .frame_valid   (frame_valid),
      .align_wrap    (align_wrap)
   );

   always #5 adc_clock = ~adc_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         fails = fails + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge adc_clock);
      #1;
   endtask

   task automatic restart(input logic [7:0] data);
      rst         = 1'b1;
      enable      = 1'b1;
      mmcm_locked = 1'b1;
      frame_data  = data;
      tick;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  nslip;
      int  last_t;
      int  first_t;
      int  min_gap;
      int  fv_tick;
      bit  prev_bs;
      bit  double_bs;
      bit  slip_seen;
      bit  fv_seen;

      lane_words[0] = 8'h1E;
      lane_words[1] = 8'h3C;
      lane_words[2] = 8'h78;
      lane_words[3] = 8'hF0;

      // Reset values, and a lane already aligned: valid 81 cycles after leaving IDLE
      rst = 1'b1; enable = 1'b1; mmcm_locked = 1'b1; frame_data = 8'hF0;
      #1;
      check("rst_serdes_rst", serdes_rst, 1);
      check("rst_bitslip", bitslip, 0);
      check("rst_bitslip_count", bitslip_count, 0);
      check("rst_frame_valid", frame_valid, 0);
      check("rst_align_wrap", align_wrap, 0);
      tick; tick;
      rst = 1'b0;
      tick;
      check("leave_idle_serdes_rst", serdes_rst, 0);
      slip_seen = 0;
      repeat (80) begin
         tick;
         if (bitslip) slip_seen = 1;
      end
      check("aligned_fv_at_80", frame_valid, 0);
      tick;
      check("aligned_fv_at_81", frame_valid, 1);
      check("aligned_no_slip", slip_seen, 0);
      check("aligned_count", bitslip_count, 0);

      // Miss tolerance in ALIGNED
      frame_data = 8'h00;
      repeat (3) tick;
      check("miss3_fv", frame_valid, 1);
      frame_data = 8'hF0;
      tick;
      check("miss3_recover_fv", frame_valid, 1);
      frame_data = 8'h00;
      repeat (3) tick;
      check("miss4_fv_before", frame_valid, 1);
      tick;
      frame_data = 8'hF0;
      check("miss4_fv", frame_valid, 0);
      check("miss4_state", dut.state, ST_CHECK);
      check("miss4_count", bitslip_count, 0);

      // Rotated lane: aligned after three slips
      restart(lane_words[0]);
      nslip = 0; last_t = -100; first_t = -1; min_gap = 1000; fv_tick = -1;
      prev_bs = 0; double_bs = 0;
      for (int t = 0; t < 300 && fv_tick < 0; t++) begin
         tick;
         if (bitslip) begin
            if (prev_bs) double_bs = 1;
            if (nslip == 0) first_t = t;
            else if (t - last_t < min_gap) min_gap = t - last_t;
            last_t = t;
            nslip  = nslip + 1;
            if (nslip < 4) frame_data = lane_words[nslip];
         end
         prev_bs = bitslip;
         if (frame_valid) fv_tick = t;
      end
      check("rot_first_slip_cycle", first_t, 17);
      check("rot_slip_total", nslip, 3);
      check("rot_single_cycle", double_bs, 0);
      check("rot_spacing_ge18", min_gap >= 18, 1);
      check("rot_fv_cycle", fv_tick, 135);
      check("rot_count", bitslip_count, 3);
      check("rot_align_wrap", align_wrap, 0);

      // Never aligned: count walks 1..7,0 and wrap flag sets on the 8th slip
      restart(8'h00);
      nslip = 0; fv_seen = 0;
      for (int t = 0; t < 250 && nslip < 8; t++) begin
         tick;
         if (frame_valid) fv_seen = 1;
         if (bitslip) begin
            nslip = nslip + 1;
            check($sformatf("wrap_count_slip%0d", nslip), bitslip_count, nslip % 8);
            check($sformatf("wrap_flag_slip%0d", nslip), align_wrap, (nslip == 8) ? 1 : 0);
         end
      end
      check("wrap_slip_total", nslip, 8);
      check("wrap_fv_never", fv_seen, 0);
      enable = 1'b0;
      tick;
      check("wrap_cleared_idle", align_wrap, 0);
      check("disable_serdes_rst", serdes_rst, 1);

      // Lock loss during SETTLE after two slips
      restart(8'h00);
      nslip = 0;
      for (int t = 0; t < 100 && nslip < 2; t++) begin
         tick;
         if (bitslip) nslip = nslip + 1;
      end
      check("unlock_two_slips", nslip, 2);
      repeat (3) tick;
      check("unlock_pre_state", dut.state, ST_SETTLE);
      mmcm_locked = 1'b0;
      tick;
      check("unlock_serdes_rst", serdes_rst, 1);
      check("unlock_count", bitslip_count, 0);
      check("unlock_fv", frame_valid, 0);
      mmcm_locked = 1'b1;
      tick;
      check("relock_state", dut.state, ST_SETTLE);
      check("relock_serdes_rst", serdes_rst, 0);

      // Asynchronous reset in the middle of a slip pulse
      restart(8'h00);
      slip_seen = 0;
      for (int t = 0; t < 50 && !slip_seen; t++) begin
         tick;
         if (bitslip) slip_seen = 1;
      end
      check("midslip_pulse_seen", bitslip, 1);
      #2 rst = 1'b1;
      #1;
      check("midslip_bitslip", bitslip, 0);
      check("midslip_serdes_rst", serdes_rst, 1);
      check("midslip_count", bitslip_count, 0);
      check("midslip_fv", frame_valid, 0);
      check("midslip_wrap", align_wrap, 0);
      check("midslip_state", dut.state, ST_IDLE);
      rst = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/clk_align_fsm.md
CLK_ALIGN_FSM -- requirements
Module: clk_align_fsm

Interface
REQ-001 Parameter DESER_WIDTH, default 8: bits per deserialized frame word; legal 4..8.
REQ-002 Parameter FRAME_PATTERN, default 8'hF0: expected frame-lane word when aligned.
REQ-003 Parameter SETTLE_CYCLES, default 16: wait after serdes release or bitslip before sampling.
REQ-004 Parameter CHECK_CYCLES, default 64: consecutive matching words needed to declare alignment.
REQ-005 Parameter MISS_LIMIT, default 4: consecutive mismatches in ALIGNED that drop alignment.
REQ-006 One clock, adc_clock; reset rst is asynchronous and active-high.
REQ-007 adc_clock  in  1  divided ADC frame clock; all logic on its rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 enable  in  1  alignment enable, driven by the enable_adc register bit.
REQ-010 mmcm_locked  in  1  ADC clocking MMCM lock.
REQ-011 frame_data  in  DESER_WIDTH  deserialized frame-clock lane word.
REQ-012 serdes_rst  out  1  reset to the ISERDES blocks.
REQ-013 bitslip  out  1  one-cycle bitslip pulse to the ISERDES blocks.
REQ-014 bitslip_count  out  4  bitslips applied since last serdes release (feeds register bitslip_count).
REQ-015 frame_valid  out  1  alignment achieved (feeds register clk_align_frame_valid).
REQ-016 align_wrap  out  1  sticky: bitslip_count wrapped without achieving alignment.

Function
REQ-017 States SHALL be IDLE, SETTLE, CHECK, SLIP, ALIGNED; all outputs registered.
REQ-018 IDLE: serdes_rst=1, bitslip=0, bitslip_count=0, frame_valid=0, settle/match/miss counters cleared; exit to SETTLE when enable and mmcm_locked are both 1.
REQ-019 SETTLE: serdes_rst=0; counts SETTLE_CYCLES cycles, then CHECK with match counter cleared.
REQ-020 CHECK: each cycle frame_data==FRAME_PATTERN increments match counter; at CHECK_CYCLES matches go to ALIGNED; any mismatch goes to SLIP immediately.
REQ-021 SLIP: bitslip=1 for exactly one cycle; bitslip_count increments; next state SETTLE.
REQ-022 bitslip_count SHALL wrap from DESER_WIDTH-1 to 0 on increment; wrap sets align_wrap, which clears only in IDLE or on rst.
REQ-023 ALIGNED: frame_valid=1; mismatch increments miss counter, match clears it; at MISS_LIMIT consecutive misses frame_valid=0 and go to CHECK, bitslip_count retained.
REQ-024 From any non-IDLE state, enable=0 or mmcm_locked=0 SHALL force IDLE next cycle; this takes priority over every other transition, including a pending slip.
REQ-025 frame_valid SHALL rise one cycle after the CHECK_CYCLES-th consecutive matching word is sampled.
REQ-026 Minimum spacing between bitslip pulses SHALL be SETTLE_CYCLES+2 cycles.
REQ-027 Counters SHALL be sized by clog2 of their parameter and SHALL not overflow.

Reset
REQ-028 rst asserted: state=IDLE, serdes_rst=1, bitslip=0, bitslip_count=0, frame_valid=0, align_wrap=0, all counters 0, asynchronously.
REQ-029 rst deasserted: FSM leaves IDLE no earlier than the first adc_clock edge with enable and mmcm_locked high.

Structure
REQ-030 State encoding localparams and the 4-bit bitslip_count width SHALL live in a shared package used by clk_align_fsm and the register block.
REQ-031 A sub-module frame_match_counter (saturating match/miss counter with clear) is natural; the rest is flat.

Verification
REQ-032 Reset, enable=1, mmcm_locked=1, frame_data always 8'hF0 -> no bitslip, bitslip_count=0, frame_valid=1 exactly 16+64+1 cycles after leaving IDLE.
REQ-033 Lane rotated so aligned after 3 slips (8'h1E,8'h3C,8'h78 then 8'hF0) -> three single-cycle bitslip pulses >=18 cycles apart, bitslip_count=3, frame_valid=1, align_wrap=0.
REQ-034 frame_data never 8'hF0 -> bitslip_count cycles 0..7,0; align_wrap=1 after 8th slip; frame_valid stays 0.
REQ-035 In ALIGNED inject 3 mismatches then 8'hF0 -> frame_valid stays 1; inject 4 consecutive mismatches -> frame_valid=0 next cycle, state CHECK, bitslip_count unchanged.
REQ-036 Drop mmcm_locked during SETTLE after 2 slips -> next cycle serdes_rst=1, bitslip_count=0, frame_valid=0; relock restarts from SETTLE.
REQ-037 Assert rst mid-SLIP -> bitslip deasserts asynchronously, all outputs at REQ-028 values.
